deconv_row_multiplier: RTL

Upstream stage of the transposed-convolution row datapath: takes one feature-map row and one kernel row, forms every feature×kernel product with N_COL_KERNEL multipliers (one feature pixel per cycle), and presents the packed outer-product vector to the overlap-add shift stage. The result is held stable under a valid/ready handshake until the consumer has finished shifting it in.

---
 rtl/deconv_row_multiplier.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/deconv_row_multiplier.sv
// deconv_row_multiplier
//
// Upstream stage of the transposed-convolution row datapath. Accepts one feature-map row and
// one kernel row, then over N_COL_FEATURE cycles multiplies one feature pixel by every kernel
// tap in parallel, building the packed outer-product vector slice by slice (pixel 0 in the
// LSBs). The finished vector is held under a valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      operand row pair valid
//   in_ready      block idle, operands will be accepted on the next edge
//   feature_row   pixel f at [f*BIT_WIDTH +: BIT_WIDTH]
//   kernel_row    tap k at [k*BIT_WIDTH +: BIT_WIDTH]
//   out_valid     data_out complete and stable
//   out_ready     consumer has taken data_out
//   data_out      product f*k at [(f*N_COL_KERNEL+k)*2*BIT_WIDTH +: 2*BIT_WIDTH]
//   data_strobe   bit n covers data_out[4n +: 4]
//   busy          state is not idle

module deconv_row_multiplier #(
    parameter int unsigned BIT_WIDTH     = 8,
    parameter int unsigned N_COL_FEATURE = 8,
    parameter int unsigned N_COL_KERNEL  = 5,
    parameter int unsigned SIGNED        = 1,
    parameter int unsigned N_PIX_IN      = N_COL_FEATURE * N_COL_KERNEL,
    parameter int unsigned STRB_WIDTH    = 2 * BIT_WIDTH * N_PIX_IN / 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BIT_WIDTH*N_COL_FEATURE-1:0]  feature_row,
    input  logic [BIT_WIDTH*N_COL_KERNEL-1:0]   kernel_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2*BIT_WIDTH*N_PIX_IN-1:0]     data_out,
    output logic [STRB_WIDTH-1:0]               data_strobe,
    output logic                                busy
);

    localparam int unsigned ProdW  = 2 * BIT_WIDTH;
    localparam int unsigned SliceW = ProdW * N_COL_KERNEL;
    localparam int unsigned SliceS = SliceW / 4;
    localparam int unsigned CntW   = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
    localparam logic [CntW-1:0] LastCol = CntW'(N_COL_FEATURE - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                             state_q, state_d;
    logic [BIT_WIDTH*N_COL_FEATURE-1:0] feature_q, feature_d;
    logic [BIT_WIDTH*N_COL_KERNEL-1:0]  kernel_q, kernel_d;
    logic [CntW-1:0]                    col_cnt_q, col_cnt_d;
    logic [2*BIT_WIDTH*N_PIX_IN-1:0]    data_q, data_d;
    logic [STRB_WIDTH-1:0]              strobe_q, strobe_d;
    logic                               out_valid_q, out_valid_d;
    logic                               in_ready_q, in_ready_d;

    logic [BIT_WIDTH-1:0] pixel;
    logic [SliceW-1:0]    row_prod;

    assign pixel = feature_q[col_cnt_q*BIT_WIDTH +: BIT_WIDTH];

    // One multiplier per kernel tap; operands are extended to the full product width so the
    // low 2*BIT_WIDTH bits of the product are exact for both signed and unsigned operands.
    for (genvar k = 0; k < N_COL_KERNEL; k++) begin : g_mul
        logic [BIT_WIDTH-1:0] tap;
        assign tap = kernel_q[k*BIT_WIDTH +: BIT_WIDTH];
        if (SIGNED != 0) begin : g_signed
            assign row_prod[k*ProdW +: ProdW] =
                $signed({{BIT_WIDTH{pixel[BIT_WIDTH-1]}}, pixel}) *
                $signed({{BIT_WIDTH{tap[BIT_WIDTH-1]}}, tap});
        end else begin : g_unsigned
            assign row_prod[k*ProdW +: ProdW] =
                {{BIT_WIDTH{1'b0}}, pixel} * {{BIT_WIDTH{1'b0}}, tap};
        end
    end

    always_comb begin
        state_d     = state_q;
        feature_d   = feature_q;
        kernel_d    = kernel_q;
        col_cnt_d   = col_cnt_q;
        data_d      = data_q;
        strobe_d    = strobe_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    feature_d = feature_row;
                    kernel_d  = kernel_row;
                    data_d    = '0;
                    strobe_d  = '0;
                    col_cnt_d = '0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                data_d[col_cnt_q*SliceW +: SliceW]   = row_prod;
                strobe_d[col_cnt_q*SliceS +: SliceS] = '1;
                if (col_cnt_q == LastCol) begin
                    col_cnt_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    col_cnt_d = col_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered ready: reflects the state the block will be in after this edge.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            feature_q   <= '0;
            kernel_q    <= '0;
            col_cnt_q   <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            feature_q   <= feature_d;
            kernel_q    <= kernel_d;
            col_cnt_q   <= col_cnt_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign data_out    = data_q;
    assign data_strobe = strobe_q;
    assign busy        = (state_q != StIdle);

endmodule
